oled_text_renderer: RTL

//  Frame sequencer on the consumer side of the OLED text-string ROM. It walks base_addr over all 4 pages x 16 chars x 8 columns and takes ascii_data from the ROM.
//  It looks up each glyph column in an external 8x8 font ROM and streams SSD1306 page-address commands and glyph bytes to the SPI byte transmitter over valid/ready.
//  One start pulse produces one full 128x32 frame of 524 bytes.

---
 rtl/oled_pkg.sv | 45 ++++
 rtl/oled_byte_hold.sv | 32 +++
 rtl/oled_text_renderer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED text renderer: FSM states, SSD1306
// command bytes, frame geometry and the glyph substitution rule.
package oled_pkg;

    localparam int NUM_PAGES       = 4;
    localparam int NUM_CHARS       = 16;
    localparam int GLYPH_W         = 8;
    localparam int CMDS_PER_PAGE   = 3;
    localparam int BYTES_PER_FRAME = NUM_PAGES * (CMDS_PER_PAGE + NUM_CHARS * GLYPH_W);

    localparam logic [1:0] PAGE_LAST = 2'(NUM_PAGES - 1);
    localparam logic [3:0] CHAR_LAST = 4'(NUM_CHARS - 1);
    localparam logic [2:0] COL_LAST  = 3'(GLYPH_W - 1);
    localparam logic [1:0] CMD_LAST  = 2'(CMDS_PER_PAGE - 1);

    localparam logic [7:0] CMD_PAGE_BASE = 8'hB0;
    localparam logic [7:0] CMD_COL_LO    = 8'h00;
    localparam logic [7:0] CMD_COL_HI    = 8'h10;

    // Non-ASCII codes (bit 7 set) render as a blank space glyph.
    localparam logic [6:0] SUBST_GLYPH = 7'h20;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_FETCH = 3'd2,
        ST_LATCH = 3'd3,
        ST_SEND  = 3'd4,
        ST_FIN   = 3'd5
    } state_t;

    function automatic logic [6:0] glyph_of(input logic [7:0] ascii);
        return ascii[7] ? SUBST_GLYPH : ascii[6:0];
    endfunction

    // Page preamble: set page address, then column address low/high nibble = 0.
    function automatic logic [7:0] cmd_byte(input logic [1:0] idx, input logic [1:0] page);
        case (idx)
            2'd0:    return CMD_PAGE_BASE | {6'd0, page};
            2'd1:    return CMD_COL_LO;
            default: return CMD_COL_HI;
        endcase
    endfunction

endpackage

// File: rtl/oled_byte_hold.sv
// Output holding register for the SPI byte stream: keeps tx_data/tx_dc/tx_valid
// stable while the transmitter stalls.
module oled_byte_hold (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       load_dc,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       tx_dc
);

    // Handshake: a byte transfers on a rising edge where tx_valid && tx_ready.
    // Once raised, tx_valid and the payload hold until that edge (only rst
    // drops them early); load is only issued while tx_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            tx_dc    <= 1'b0;
        end else if (load) begin
            tx_valid <= 1'b1;
            tx_data  <= load_data;
            tx_dc    <= load_dc;
        end else if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/oled_text_renderer.sv
// Frame sequencer: walks the 4x16 text buffer, looks up glyph columns and streams
// SSD1306 page commands plus pixel bytes. Optional cursor inversion: OLED_CURSOR_EN.
module oled_text_renderer
    import oled_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [8:0] base_addr,
    input  logic [7:0] ascii_data,
    output logic [9:0] font_addr,
    input  logic [7:0] font_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_dc,
`ifdef OLED_CURSOR_EN
    input  logic       cursor_en,
    input  logic [5:0] cursor_pos,
`endif
    output state_t     dbg_state
);

    state_t     state, state_nxt;
    logic [1:0] page;
    logic [3:0] chr;
    logic [2:0] col;
    logic [1:0] cmd_idx;
    logic       hs;
    logic       last_col;
    logic       last_char;
    logic       load;
    logic [7:0] load_data;
    logic       load_dc;
    logic [7:0] font_byte;

    assign hs        = tx_valid && tx_ready;
    assign last_col  = (col == COL_LAST);
    assign last_char = last_col && (chr == CHAR_LAST);
    assign base_addr = {page, chr, col};
    assign dbg_state = state;

`ifdef OLED_CURSOR_EN
    logic cursor_hit;

    // Captured alongside the font lookup so it lines up with font_data in LATCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            cursor_hit <= 1'b0;
        end else if (state == ST_FETCH) begin
            cursor_hit <= cursor_en && ({page, chr} == cursor_pos);
        end
    end

    assign font_byte = font_data ^ {8{cursor_hit}};
`else
    assign font_byte = font_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            page    <= 2'd0;
            chr     <= 4'd0;
            col     <= 3'd0;
            cmd_idx <= 2'd0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && start) begin
                page    <= 2'd0;
                chr     <= 4'd0;
                col     <= 3'd0;
                cmd_idx <= 2'd0;
            end
            if (state == ST_CMD && hs) begin
                cmd_idx <= (cmd_idx == CMD_LAST) ? 2'd0 : cmd_idx + 2'd1;
            end
            // col carries into char, char carries into page; all wrap to zero.
            if (state == ST_SEND && hs) begin
                col <= col + 3'd1;
                if (last_col) begin
                    chr <= chr + 4'd1;
                    if (chr == CHAR_LAST) begin
                        page <= page + 2'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        font_addr = 10'd0;
        load      = 1'b0;
        load_data = font_byte;
        load_dc   = 1'b1;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_CMD;
                end
            end
            ST_CMD: begin
                busy      = 1'b1;
                load_dc   = 1'b0;
                load_data = cmd_byte(cmd_idx, page);
                if (!tx_valid) begin
                    load = 1'b1;
                end else if (tx_ready && cmd_idx == CMD_LAST) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                busy      = 1'b1;
                font_addr = {glyph_of(ascii_data), col};
                state_nxt = ST_LATCH;
            end
            ST_LATCH: begin
                busy      = 1'b1;
                load      = 1'b1;
                state_nxt = ST_SEND;
            end
            ST_SEND: begin
                busy = 1'b1;
                if (hs) begin
                    if (!last_char) begin
                        state_nxt = ST_FETCH;
                    end else if (page == PAGE_LAST) begin
                        state_nxt = ST_FIN;
                    end else begin
                        state_nxt = ST_CMD;
                    end
                end
            end
            ST_FIN: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    oled_byte_hold u_byte_hold (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_data),
        .load_dc   (load_dc),
        .tx_ready  (tx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_dc     (tx_dc)
    );

endmodule
